// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the main store access sequencer.
//   ADDR_W      - selection register / RAM address width
//   CNT_W       - width of the access-time wait counter (covers 0..15)
//   mem_state_e - sequencer states
//   RAM_W()     - stored word width: data word plus one parity bit
package mem_access_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [2:0] {
      StIdle,
      StAccess,
      StWait,
      StCapture,
      StDone
   } mem_state_e;

   function automatic int unsigned RAM_W(input int unsigned word_w);
      return word_w + 1;
   endfunction

endpackage

// File: rtl/mem_parity_calc.sv
// mem_parity_calc: odd-parity generator for a data word.
//   i_data - word to protect
//   o_par  - bit that makes {o_par, i_data} contain an odd number of ones
module mem_parity_calc #(
   parameter int unsigned WIDTH = 31
) (
   input  logic [WIDTH-1:0] i_data,
   output logic             o_par
);

   assign o_par = ~^i_data;

endmodule

// File: rtl/mem_access.sv
// mem_access: sequences one read or write of the main store RAM per request.
// A request from the control unit is latched in idle, the RAM is strobed for one
// cycle, the store access time is modelled by a wait counter, the result word is
// captured and a one-cycle done pulse is returned.
//
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   do_mem_read_from_pu / _write_    - request pulses (write wins if both)
//   sel_value_from_sel               - access address
//   wr_data_from_au                  - word to write
//   rd_data_to_au, mem_value_to_pnl  - last word read or written
//   mem_busy_to_pu, mem_done_to_pu   - access in progress / completion pulse
//   mem_parity_err_to_pnl            - sticky read parity error
//   clr_err_from_pnl                 - clears the parity error flag
//   ram_en/we/addr/wdata, ram_rdata  - single-port synchronous RAM interface
//
// Build option: define MEM_PARITY_EN to store odd parity in ram_wdata[WORD_W]
// and check it on reads; otherwise the parity bit is written as 0 and the error
// flag is tied low.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned WORD_W        = 31,
   parameter int unsigned ACCESS_CYCLES = 3
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      do_mem_read_from_pu,
   input  logic                      do_mem_write_from_pu,
   input  logic [ADDR_W-1:0]         sel_value_from_sel,
   input  logic [WORD_W-1:0]         wr_data_from_au,
   output logic [WORD_W-1:0]         rd_data_to_au,
   output logic [WORD_W-1:0]         mem_value_to_pnl,
   output logic                      mem_busy_to_pu,
   output logic                      mem_done_to_pu,
   output logic                      mem_parity_err_to_pnl,
   input  logic                      clr_err_from_pnl,
   output logic                      ram_en,
   output logic                      ram_we,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [RAM_W(WORD_W)-1:0]  ram_wdata,
   input  logic [RAM_W(WORD_W)-1:0]  ram_rdata
);

   mem_state_e        r_state;
   mem_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_wpar;
   logic              r_op_wr;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_rd;
   logic              w_req;
   logic              w_wpar;

   assign w_req = do_mem_read_from_pu | do_mem_write_from_pu;

   always_comb begin
      w_state_nxt = r_state;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      unique case (r_state)
         StIdle:    if (w_req) w_state_nxt = StAccess;
         StAccess: begin
            ram_en      = 1'b1;
            ram_we      = r_op_wr;
            w_state_nxt = (r_cnt != '0) ? StWait : StCapture;
         end
         // Counter value n means n wait cycles remain, including this one.
         StWait:    if (r_cnt <= CNT_W'(1)) w_state_nxt = StCapture;
         StCapture: w_state_nxt = StDone;
         StDone:    w_state_nxt = StIdle;
         default:   w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wpar  <= 1'b0;
         r_op_wr <= 1'b0;
         r_cnt   <= '0;
         r_rd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            StIdle: begin
               if (w_req) begin
                  r_addr  <= sel_value_from_sel;
                  r_wdata <= wr_data_from_au;
                  r_wpar  <= w_wpar;
                  r_op_wr <= do_mem_write_from_pu;
                  r_cnt   <= CNT_W'(ACCESS_CYCLES);
               end
            end
            StWait:    r_cnt <= r_cnt - 1'b1;
            StCapture: r_rd  <= r_op_wr ? r_wdata : ram_rdata[WORD_W-1:0];
            default: ;
         endcase
      end
   end

`ifdef MEM_PARITY_EN
   logic w_rpar;
   logic w_rd_bad;
   logic r_err;

   mem_parity_calc #(
      .WIDTH (WORD_W)
   ) u_par_wr (
      .i_data (wr_data_from_au),
      .o_par  (w_wpar)
   );

   mem_parity_calc #(
      .WIDTH (WORD_W)
   ) u_par_rd (
      .i_data (ram_rdata[WORD_W-1:0]),
      .o_par  (w_rpar)
   );

   assign w_rd_bad = (r_state == StCapture) && !r_op_wr && (w_rpar != ram_rdata[WORD_W]);

   // Set has priority over a clear arriving in the same cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_err <= 1'b0;
      end else if (w_rd_bad) begin
         r_err <= 1'b1;
      end else if (clr_err_from_pnl) begin
         r_err <= 1'b0;
      end
   end

   assign mem_parity_err_to_pnl = r_err;
`else
   logic w_unused_par;

   assign w_wpar                = 1'b0;
   assign w_unused_par          = ^{clr_err_from_pnl, ram_rdata[WORD_W]};
   assign mem_parity_err_to_pnl = 1'b0;
`endif

   assign ram_addr         = r_addr;
   assign ram_wdata        = {r_wpar, r_wdata};
   assign rd_data_to_au    = r_rd;
   assign mem_value_to_pnl = r_rd;
   assign mem_busy_to_pu   = (r_state != StIdle);
   assign mem_done_to_pu   = (r_state == StDone);

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory access sequencer between the 12-bit selection register output and the main store RAM.
- On a read or write strobe from the control unit (PU), it latches the selection-register address and the AU write word, then drives a single-port synchronous RAM.
- It models the store's access time with a wait counter and returns the word to the AU and panel with a one-cycle done pulse.

Parameters:
- WORD_W, 31, data word width in bits.
- ACCESS_CYCLES, 3, extra wait cycles after the RAM strobe; legal range 0..15.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- do_mem_read_from_pu  in  1  read request pulse
- do_mem_write_from_pu  in  1  write request pulse
- sel_value_from_sel  in  12  address from the selection register
- wr_data_from_au  in  WORD_W  word to be written
- rd_data_to_au  out  WORD_W  last word read or written
- mem_value_to_pnl  out  WORD_W  same value as rd_data_to_au, for panel display
- mem_busy_to_pu  out  1  access in progress
- mem_done_to_pu  out  1  one-cycle completion pulse
- mem_parity_err_to_pnl  out  1  sticky parity error flag
- clr_err_from_pnl  in  1  clears the parity error flag
- ram_en  out  1  RAM strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  12  RAM address
- ram_wdata  out  WORD_W+1  RAM write data; top bit is parity
- ram_rdata  in  WORD_W+1  RAM read data; 1-cycle latency, held while ram_en is low

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; all outputs 0, including rd_data, addr/data latches, counter and error flag. RAM contents are not touched.
- Reset mid-access: the access aborts immediately, ram_en drops in the same instant, and no done pulse is produced.
- States:
  - IDLE: requests are sampled only here. At the edge where a request is seen: latch addr and wdata, record op (write if do_mem_write_from_pu), load counter=ACCESS_CYCLES, go to ACCESS.
  - ACCESS (1 cycle): ram_en=1, ram_we=op, ram_addr=latched addr, ram_wdata={parity, wdata}. Next state is WAIT if counter>0, else CAPTURE.
  - WAIT: the counter decrements each cycle; go to CAPTURE when it reaches 1. ram_en=0 and ram_addr holds.
  - CAPTURE (1 cycle):
    - Read: rd_reg <= ram_rdata[WORD_W-1:0] at the end of the cycle.
    - Write: rd_reg <= latched wdata.
    - Parity check happens here (see Optional Feature).
  - DONE (1 cycle): mem_done_to_pu=1, then IDLE.
- mem_busy_to_pu=1 in ACCESS, WAIT, CAPTURE and DONE; 0 only in IDLE.
- Latency: request sampled at edge E0 → done high during the cycle after edge E0+ACCESS_CYCLES+2.
- Requests seen while busy are ignored entirely; they are not queued.
- Simultaneous read and write strobes: the write wins; the read is dropped.
- ram_addr/ram_wdata are held stable from ACCESS through DONE.
- rd_data_to_au and mem_value_to_pnl hold their value until the next CAPTURE.
- Address 12'o7777 is an ordinary location; there is no wrap logic.

Optional Feature:
- MEM_PARITY_EN defined:
  - ram_wdata[WORD_W] carries odd parity of the write word.
  - On a read in CAPTURE, a parity mismatch over ram_rdata sets mem_parity_err_to_pnl.
  - The flag is sticky until reset or clr_err_from_pnl; if set and clear land in the same cycle, set wins.
  - The data is still delivered and done still pulses.
- MEM_PARITY_EN undefined: ram_wdata[WORD_W]=0, no check is performed, and mem_parity_err_to_pnl is tied 0.

Decomposition:
- Package mem_access_pkg holds:
  - ADDR_W=12
  - the state enum (IDLE, ACCESS, WAIT, CAPTURE, DONE)
  - the RAM_W(WORD_W) width helper
- One sub-module, mem_parity_calc: combinational XOR-reduce producing the odd-parity bit. It is instantiated twice (write generation, read check) and only under MEM_PARITY_EN.

Test Plan:
- Write then read, ACCESS_CYCLES=3: write 0o1234567 at addr 0o0042, then read 0o0042 → ram_en high exactly 1 cycle per access; done at E0+5 each time; rd_data_to_au=0o1234567 after the read.
- Read and write strobes together in one cycle, addr 0o0100, data 0o7 → exactly one RAM write (ram_we=1) with data 0o7; no read access issued.
- Read strobe repeated every cycle of an access → exactly one access; busy stays high through DONE; the next access starts only after busy falls.
- resetn pulsed low during WAIT → ram_en=0, busy=0, rd_data=0 immediately; no done pulse; a new read after reset completes normally.
- ACCESS_CYCLES=0, read addr 0o7777 → state goes ACCESS→CAPTURE directly; done at E0+2; no wrap anomaly at the top address.
- MEM_PARITY_EN, RAM model flips the parity bit on a read → data returned, done pulses, err=1 and stays 1 until clr_err_from_pnl; a clean read afterwards leaves it at 0.
